// File: rtl/cook_timer_pkg.sv
// Shared definitions for the microwave cook timer: state encoding, limits and
// the seconds-to-MM:SS conversion used by the display path.
package cook_timer_pkg;

  localparam int unsigned MAX_SEC_DEF = 5999;
  localparam int unsigned SEC_W       = 13;
  localparam int unsigned DISP_W      = 14;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // mm*100 + ss, so the FND stage can split digits with plain decimal math
  function automatic logic [DISP_W-1:0] sec_to_mmss(input logic [SEC_W-1:0] sec);
    logic [SEC_W-1:0] mm;
    logic [SEC_W-1:0] ss;
    mm = sec / SEC_W'(60);
    ss = sec % SEC_W'(60);
    return DISP_W'(mm) * DISP_W'(100) + DISP_W'(ss);
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Free-running period counter; tick is high for one cycle every PERIOD enabled cycles.
module sec_tick_gen #(
  parameter int unsigned PERIOD = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(PERIOD - 1));
  assign tick   = en && w_wrap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/cook_timer.sv
// Microwave cook-time FSM and countdown feeding the FND controller.
// Optional display blink in PAUSE/DONE is built when COOK_TIMER_BLINK_EN is defined.
module cook_timer
  import cook_timer_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned MAX_SEC   = MAX_SEC_DEF,
  parameter int unsigned ADD_SMALL = 30,
  parameter int unsigned ADD_BIG   = 60,
  parameter int unsigned DONE_SEC  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_add_s,
  input  logic              btn_add_b,
  input  logic              btn_start,
  input  logic              btn_stop,
  input  logic              door_open,
  output logic [DISP_W-1:0] disp_data,
  output logic              idle_animation,
  output logic              running,
  output logic              buzzer_en,
  output logic              done_pulse,
  output logic              disp_blank
);

  localparam int unsigned DCW = (DONE_SEC > 1) ? $clog2(DONE_SEC) : 1;

  state_e            r_state, w_state_nxt;
  logic [SEC_W-1:0]  r_remain, w_remain_nxt;
  logic [DCW-1:0]    r_done_cnt, w_done_cnt_nxt;
  logic [DISP_W-1:0] r_disp;
  logic              r_idle, r_run, r_buzz, r_pulse, w_pulse_nxt;
  logic              w_tick, w_tick_en, w_tick_clr;
  logic              w_start, w_add_b, w_add_s, w_has_add;
  logic [SEC_W-1:0]  w_add_val, w_acc;
  logic [SEC_W:0]    w_sum;

  // One button acts per cycle: stop > start > add_b > add_s
  assign w_start   = btn_start && !btn_stop;
  assign w_add_b   = btn_add_b && !btn_start && !btn_stop;
  assign w_add_s   = btn_add_s && !btn_add_b && !btn_start && !btn_stop;
  assign w_has_add = w_add_b || w_add_s;
  assign w_add_val = w_add_b ? SEC_W'(ADD_BIG) : (w_add_s ? SEC_W'(ADD_SMALL) : '0);

  assign w_sum = {1'b0, r_remain} - (SEC_W+1)'(w_tick && (r_state == ST_RUN))
               + (SEC_W+1)'(w_add_val);
  assign w_acc = (w_sum > (SEC_W+1)'(MAX_SEC)) ? SEC_W'(MAX_SEC) : w_sum[SEC_W-1:0];

  // Counter restarts on every entry to RUN/DONE and stays at zero elsewhere
  assign w_tick_en  = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign w_tick_clr = (w_state_nxt != r_state) ||
                      !((w_state_nxt == ST_RUN) || (w_state_nxt == ST_DONE));

  sec_tick_gen #(.PERIOD(CLK_HZ)) u_sec_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (w_tick_clr),
    .en    (w_tick_en),
    .tick  (w_tick)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_remain_nxt   = r_remain;
    w_done_cnt_nxt = r_done_cnt;
    w_pulse_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_remain_nxt = '0;
        if (w_start && !door_open) begin
          w_state_nxt  = ST_RUN;
          w_remain_nxt = SEC_W'(ADD_SMALL);
        end else if (w_has_add) begin
          w_state_nxt  = ST_SET;
          w_remain_nxt = w_add_val;
        end
      end
      ST_SET, ST_PAUSE: begin
        if (btn_stop) begin
          w_state_nxt  = ST_IDLE;
          w_remain_nxt = '0;
        end else if (w_start && !door_open) begin
          w_state_nxt = ST_RUN;
        end else if (w_has_add) begin
          w_remain_nxt = w_acc;
        end
      end
      ST_RUN: begin
        w_remain_nxt = w_acc;
        if (w_acc == '0) begin
          w_state_nxt    = ST_DONE;
          w_done_cnt_nxt = '0;
          w_pulse_nxt    = 1'b1;
        end else if (door_open || btn_stop) begin
          w_state_nxt = ST_PAUSE;
        end
      end
      ST_DONE: begin
        if (btn_stop || w_start) begin
          w_state_nxt = ST_IDLE;
        end else if (w_has_add) begin
          w_state_nxt  = ST_SET;
          w_remain_nxt = w_add_val;
        end else if (w_tick) begin
          if (r_done_cnt == DCW'(DONE_SEC - 1)) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_done_cnt_nxt = r_done_cnt + DCW'(1);
          end
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_remain_nxt = '0;
      end
    endcase
  end

  // Mode flags are registered from next state so they track r_state exactly
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_remain   <= '0;
      r_done_cnt <= '0;
      r_disp     <= '0;
      r_idle     <= 1'b1;
      r_run      <= 1'b0;
      r_buzz     <= 1'b0;
      r_pulse    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_remain   <= w_remain_nxt;
      r_done_cnt <= w_done_cnt_nxt;
      r_disp     <= sec_to_mmss(r_remain);
      r_idle     <= (w_state_nxt == ST_IDLE);
      r_run      <= (w_state_nxt == ST_RUN);
      r_buzz     <= (w_state_nxt == ST_DONE);
      r_pulse    <= w_pulse_nxt;
    end
  end

  assign disp_data      = r_disp;
  assign idle_animation = r_idle;
  assign running        = r_run;
  assign buzzer_en      = r_buzz;
  assign done_pulse     = r_pulse;

`ifdef COOK_TIMER_BLINK_EN
  logic w_half_tick, w_blink_en, w_blink_on_nxt, w_blink_clr;
  logic r_blank;

  assign w_blink_en     = (r_state == ST_PAUSE) || (r_state == ST_DONE);
  assign w_blink_on_nxt = (w_state_nxt == ST_PAUSE) || (w_state_nxt == ST_DONE);
  assign w_blink_clr    = (w_state_nxt != r_state) || !w_blink_on_nxt;

  sec_tick_gen #(.PERIOD(CLK_HZ / 2)) u_half_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (w_blink_clr),
    .en    (w_blink_en),
    .tick  (w_half_tick)
  );

  // Blank starts high on entry and flips every half second
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_blank <= 1'b0;
    end else if (!w_blink_on_nxt) begin
      r_blank <= 1'b0;
    end else if (w_state_nxt != r_state) begin
      r_blank <= 1'b1;
    end else if (w_half_tick) begin
      r_blank <= ~r_blank;
    end
  end

  assign disp_blank = r_blank;
`else
  assign disp_blank = 1'b0;
`endif

endmodule

// File: tb/tb_cook_timer.sv
// Directed bench for cook_timer with CLK_HZ=10: vector table plus saturation
// and mid-run reset sequences.
module tb_cook_timer;

  logic        clk;
  logic        reset;
  logic        btn_add_s, btn_add_b, btn_start, btn_stop, door_open;
  logic [13:0] disp_data;
  logic        idle_animation, running, buzzer_en, done_pulse, disp_blank;

  int n_checks;
  int n_fail;

  // btn = {add_s, add_b, start, stop, door}; md = {idle, running, buzzer, done_pulse}
  typedef struct {
    logic [4:0] btn;
    int         cyc;
    int         disp;
    logic [3:0] md;
  } vec_t;

  localparam int NV = 24;
  vec_t vt [NV];

  cook_timer #(
    .CLK_HZ    (10),
    .MAX_SEC   (5999),
    .ADD_SMALL (30),
    .ADD_BIG   (60),
    .DONE_SEC  (3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .btn_add_s      (btn_add_s),
    .btn_add_b      (btn_add_b),
    .btn_start      (btn_start),
    .btn_stop       (btn_stop),
    .door_open      (door_open),
    .disp_data      (disp_data),
    .idle_animation (idle_animation),
    .running        (running),
    .buzzer_en      (buzzer_en),
    .done_pulse     (done_pulse),
    .disp_blank     (disp_blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_mode(input string tag, input logic [3:0] md);
    chk({tag, " idle_animation"}, int'(idle_animation), int'(md[3]));
    chk({tag, " running"},        int'(running),        int'(md[2]));
    chk({tag, " buzzer_en"},      int'(buzzer_en),      int'(md[1]));
    chk({tag, " done_pulse"},     int'(done_pulse),     int'(md[0]));
  endtask

  // One-cycle button pulse launched at a falling edge
  task automatic press(input logic [4:0] b);
    btn_add_s = b[4];
    btn_add_b = b[3];
    btn_start = b[2];
    btn_stop  = b[1];
    @(negedge clk);
    btn_add_s = 1'b0;
    btn_add_b = 1'b0;
    btn_start = 1'b0;
    btn_stop  = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b0;
    btn_add_s = 1'b0;
    btn_add_b = 1'b0;
    btn_start = 1'b0;
    btn_stop  = 1'b0;
    door_open = 1'b0;

    vt[0]  = '{5'b10000,   1,   0, 4'b0000};  // add_s -> SET 30
    vt[1]  = '{5'b01000,   1,  30, 4'b0000};  // add_b -> 90
    vt[2]  = '{5'b00100,   1, 130, 4'b0100};  // start -> RUN
    vt[3]  = '{5'b00000,   9, 130, 4'b0100};
    vt[4]  = '{5'b00000,   1, 130, 4'b0100};  // first tick: remain 89
    vt[5]  = '{5'b00000,   1, 129, 4'b0100};
    vt[6]  = '{5'b00001,   1, 129, 4'b0000};  // door open -> PAUSE
    vt[7]  = '{5'b00101,   1, 129, 4'b0000};  // start ignored, door open
    vt[8]  = '{5'b00100,   1, 129, 4'b0100};  // door closed, resume
    vt[9]  = '{5'b00000,  10, 129, 4'b0100};
    vt[10] = '{5'b00000,   1, 128, 4'b0100};
    vt[11] = '{5'b00110,   1, 128, 4'b0000};  // start+stop -> PAUSE
    vt[12] = '{5'b00010,   1, 128, 4'b1000};  // stop in PAUSE -> IDLE
    vt[13] = '{5'b00000,   1,   0, 4'b1000};
    vt[14] = '{5'b00100,   1,   0, 4'b0100};  // quick start 30 s
    vt[15] = '{5'b00000, 299,   1, 4'b0100};
    vt[16] = '{5'b00000,   1,   1, 4'b0011};  // RUN -> DONE
    vt[17] = '{5'b00000,   1,   0, 4'b0010};
    vt[18] = '{5'b00000,  28,   0, 4'b0010};
    vt[19] = '{5'b00000,   1,   0, 4'b1000};  // 30 cycles of buzzer, IDLE
    vt[20] = '{5'b00100,   1,   0, 4'b0100};  // quick start again
    vt[21] = '{5'b00000, 209,  10, 4'b0100};
    vt[22] = '{5'b10000,   1,  10, 4'b0100};  // tick + add_s at remain 10
    vt[23] = '{5'b00000,   1,  39, 4'b0100};

    @(negedge clk);
    @(negedge clk);
    chk("reset disp_data", int'(disp_data), 0);
    chk_mode("reset", 4'b1000);
    chk("reset disp_blank", int'(disp_blank), 0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      door_open = vt[i].btn[0];
      press(vt[i].btn);
      for (int k = 1; k < vt[i].cyc; k++) @(negedge clk);
      chk($sformatf("v%0d disp_data", i), int'(disp_data), vt[i].disp);
      chk_mode($sformatf("v%0d", i), vt[i].md);
    end

    // Saturation: 99 x add_b + add_s = 5970, then two add_b clamp at 5999
    press(5'b00010);
    press(5'b00010);
    @(negedge clk);
    chk_mode("sat idle", 4'b1000);
    for (int i = 0; i < 99; i++) press(5'b01000);
    press(5'b10000);
    chk("sat 5940", int'(disp_data), 9900);
    @(negedge clk);
    chk("sat 5970", int'(disp_data), 9930);
    press(5'b01000);
    press(5'b01000);
    chk("sat first clamp", int'(disp_data), 9959);
    @(negedge clk);
    chk("sat hold", int'(disp_data), 9959);
    chk_mode("sat SET", 4'b0000);

    // Mid-run reset at remain = 200
    press(5'b00010);
    for (int i = 0; i < 3; i++) press(5'b01000);
    press(5'b10000);
    press(5'b00100);
    for (int i = 0; i < 101; i++) @(negedge clk);
    chk("pre-reset disp_data", int'(disp_data), 320);
    chk("pre-reset running", int'(running), 1);
    #2 reset = 1'b0;
    #1;
    chk("async reset disp_data", int'(disp_data), 0);
    chk_mode("async reset", 4'b1000);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post-reset disp_data", int'(disp_data), 0);
    chk_mode("post-reset", 4'b1000);
    for (int i = 0; i < 15; i++) @(negedge clk);
    chk("post-reset stays idle disp", int'(disp_data), 0);
    chk("post-reset stays idle", int'(idle_animation), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
